// File: rtl/qalu_pkg.sv
// Shared definitions for the queue calculator ALU: opcodes, queue commands
// and the sequencer state encoding.
package qalu_pkg;

    // Opcodes (bit 3 set marks an upstream error / no-op)
    localparam logic [3:0] OP_PUSH = 4'b0000;
    localparam logic [3:0] OP_POP  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_DIV  = 4'b0101;
    localparam logic [3:0] OP_REM  = 4'b0110;

    // Commands handed to the queue controller
    localparam logic [1:0] Q_PUSH         = 2'b00;
    localparam logic [1:0] Q_SLEEP        = 2'b01;
    localparam logic [1:0] Q_GET_AND_PUSH = 2'b10;
    localparam logic [1:0] Q_POP          = 2'b11;

    // Sequencer states: IDLE accepts work, DIV waits for the divider
    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } state_t;

endpackage

// File: rtl/qalu_divider.sv
// Restoring unsigned divider. One quotient bit per cycle; the first bit is
// produced on the start edge so that done rises STEPS-1 cycles after start
// and quotient/remainder are stable while done is high.
module qalu_divider #(
    parameter int W     = 8,
    parameter int STEPS = W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(STEPS + 1);

    logic [W-1:0]  rem_r;
    logic [W-1:0]  quo_r;
    logic [W-1:0]  dvs_r;
    logic [CW-1:0] cnt_r;
    logic          run_r;
    logic          done_r;

    logic [W-1:0]  src_rem_s;
    logic [W-1:0]  src_quo_s;
    logic [W-1:0]  src_dvs_s;
    logic [W:0]    trial_s;
    logic          fits_s;
    logic [W-1:0]  next_rem_s;
    logic [W-1:0]  next_quo_s;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        if (start) begin
            src_rem_s = {W{1'b0}};
            src_quo_s = dividend;
            src_dvs_s = divisor;
        end else begin
            src_rem_s = rem_r;
            src_quo_s = quo_r;
            src_dvs_s = dvs_r;
        end
        trial_s    = {src_rem_s, src_quo_s[W-1]} - {1'b0, src_dvs_s};
        fits_s     = ~trial_s[W];
        next_rem_s = fits_s ? trial_s[W-1:0] : {src_rem_s[W-2:0], src_quo_s[W-1]};
        next_quo_s = {src_quo_s[W-2:0], fits_s};
    end

    // Iteration registers, step counter and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r  <= {W{1'b0}};
            quo_r  <= {W{1'b0}};
            dvs_r  <= {W{1'b0}};
            cnt_r  <= {CW{1'b0}};
            run_r  <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            rem_r  <= next_rem_s;
            quo_r  <= next_quo_s;
            dvs_r  <= divisor;
            cnt_r  <= CW'(1);
            run_r  <= 1'b1;
            done_r <= 1'b0;
        end else if (run_r) begin
            rem_r <= next_rem_s;
            quo_r <= next_quo_s;
            if (cnt_r == CW'(STEPS - 1)) begin
                run_r  <= 1'b0;
                done_r <= 1'b1;
            end else begin
                cnt_r  <= cnt_r + CW'(1);
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done      = done_r;
    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/queue_alu_seq.sv
// Sequential ALU for the queue calculator. One operation per valid/ready
// handshake; single-cycle ops answer on the next cycle, DIV/REM go through
// the iterative divider. Define QALU_SAT_EN to make ADD/MUL/SUB saturate
// instead of wrapping.
module queue_alu_seq
    import qalu_pkg::*;
#(
    parameter int W         = 8,
    parameter int DIV_STEPS = W   // must equal W: one quotient bit per step
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3:0]     opcode,
    input  logic [2*W-1:0] operands,
    input  logic [W-1:0]   push_val,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   result,
    output logic [1:0]     queue_op,
    output logic           has_calc_err,
    output logic           busy
);

    // Arithmetic helpers; the saturating variants clamp instead of wrapping
`ifdef QALU_SAT_EN
    function automatic logic [W-1:0] add_op(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        return s[W] ? {W{1'b1}} : s[W-1:0];
    endfunction

    function automatic logic [W-1:0] sub_op(input logic [W-1:0] minuend, input logic [W-1:0] subtrahend);
        logic [W:0] d;
        d = {1'b0, minuend} - {1'b0, subtrahend};
        return d[W] ? {W{1'b0}} : d[W-1:0];
    endfunction

    function automatic logic [W-1:0] mul_op(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        return (|p[2*W-1:W]) ? {W{1'b1}} : p[W-1:0];
    endfunction
`else
    function automatic logic [W-1:0] add_op(input logic [W-1:0] x, input logic [W-1:0] y);
        return x + y;
    endfunction

    function automatic logic [W-1:0] sub_op(input logic [W-1:0] minuend, input logic [W-1:0] subtrahend);
        return minuend - subtrahend;
    endfunction

    function automatic logic [W-1:0] mul_op(input logic [W-1:0] x, input logic [W-1:0] y);
        return x * y;
    endfunction
`endif

    state_t        state_r;
    state_t        state_next_s;
    logic          is_rem_r;

    logic [W-1:0]  a_s;
    logic [W-1:0]  b_s;
    logic          accept_s;
    logic          is_divrem_s;
    logic          start_div_s;
    logic          load_calc_s;
    logic          load_div_s;

    logic          div_done_s;
    logic [W-1:0]  div_quo_s;
    logic [W-1:0]  div_rem_s;

    logic [W-1:0]  calc_result_s;
    logic [1:0]    calc_qop_s;
    logic          calc_err_s;

    assign a_s         = operands[2*W-1:W];
    assign b_s         = operands[W-1:0];
    assign in_ready    = (state_r == IDLE) && (!out_valid || out_ready);
    assign accept_s    = in_valid && in_ready;
    assign is_divrem_s = (opcode == OP_DIV) || (opcode == OP_REM);
    assign start_div_s = accept_s && is_divrem_s && (a_s != {W{1'b0}});
    assign load_calc_s = accept_s && !start_div_s;
    assign load_div_s  = (state_r == DIV) && div_done_s;
    assign busy        = (state_r == DIV);

    qalu_divider #(
        .W     (W),
        .STEPS (DIV_STEPS)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (start_div_s),
        .dividend  (b_s),
        .divisor   (a_s),
        .done      (div_done_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // Next-state logic: leave IDLE only for a real divide, return on done
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_div_s) begin
                    state_next_s = DIV;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DIV: begin
                if (div_done_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DIV;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register and DIV/REM selector captured at divider start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            is_rem_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (start_div_s) begin
                is_rem_r <= (opcode == OP_REM);
            end
        end
    end

    // Single-cycle datapath; DIV/REM reach here only with a zero divisor
    always_comb begin
        calc_result_s = {W{1'b0}};
        calc_qop_s    = Q_SLEEP;
        calc_err_s    = 1'b0;
        if (opcode[3]) begin
            calc_result_s = {W{1'b0}};
            calc_qop_s    = Q_SLEEP;
            calc_err_s    = 1'b0;
        end else begin
            case (opcode)
                OP_PUSH: begin
                    calc_result_s = push_val;
                    calc_qop_s    = Q_PUSH;
                end
                OP_POP: begin
                    calc_qop_s = Q_POP;
                end
                OP_ADD: begin
                    calc_result_s = add_op(a_s, b_s);
                    calc_qop_s    = Q_GET_AND_PUSH;
                end
                OP_MUL: begin
                    calc_result_s = mul_op(a_s, b_s);
                    calc_qop_s    = Q_GET_AND_PUSH;
                end
                OP_SUB: begin
                    calc_result_s = sub_op(b_s, a_s);
                    calc_qop_s    = Q_GET_AND_PUSH;
                end
                OP_DIV, OP_REM: begin
                    calc_qop_s = Q_SLEEP;
                    calc_err_s = 1'b1;
                end
                default: begin
                    calc_qop_s = Q_SLEEP;
                    calc_err_s = 1'b1;
                end
            endcase
        end
    end

    // Output register: load on a result, drop valid once consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            result       <= {W{1'b0}};
            queue_op     <= Q_SLEEP;
            has_calc_err <= 1'b0;
        end else if (load_calc_s) begin
            out_valid    <= 1'b1;
            result       <= calc_result_s;
            queue_op     <= calc_qop_s;
            has_calc_err <= calc_err_s;
        end else if (load_div_s) begin
            out_valid    <= 1'b1;
            result       <= is_rem_r ? div_rem_s : div_quo_s;
            queue_op     <= Q_GET_AND_PUSH;
            has_calc_err <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_queue_alu_seq.sv
// Self-checking bench for queue_alu_seq (W=8): directed scenarios followed by
// randomized traffic against a plain-arithmetic reference model and a
// scoreboard of expected outputs. Honours QALU_SAT_EN when defined.
module tb_queue_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [15:0] operands;
    logic [7:0]  push_val;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  result;
    logic [1:0]  queue_op;
    logic        has_calc_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_res_q[$];
    logic [1:0] exp_qop_q[$];
    logic       exp_err_q[$];

    queue_alu_seq #(.W(8), .DIV_STEPS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opcode       (opcode),
        .operands     (operands),
        .push_val     (push_val),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .queue_op     (queue_op),
        .has_calc_err (has_calc_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model straight from the operation table
    task automatic ref_model(input logic [3:0] op, input int a, input int b, input int pv,
                             output logic [7:0] r, output logic [1:0] q, output logic e);
        int v;
        r = 8'd0; q = 2'b01; e = 1'b0;
        if (op >= 4'd8) begin
            r = 8'd0; q = 2'b01; e = 1'b0;
        end else begin
            case (op)
                4'd0: begin r = pv[7:0]; q = 2'b00; end
                4'd1: begin r = 8'd0; q = 2'b11; end
                4'd2: begin
                    v = a + b;
`ifdef QALU_SAT_EN
                    if (v > 255) v = 255;
`endif
                    r = v[7:0]; q = 2'b10;
                end
                4'd3: begin
                    v = a * b;
`ifdef QALU_SAT_EN
                    if (v > 255) v = 255;
`endif
                    r = v[7:0]; q = 2'b10;
                end
                4'd4: begin
                    v = b - a;
`ifdef QALU_SAT_EN
                    if (v < 0) v = 0;
`endif
                    r = v[7:0]; q = 2'b10;
                end
                4'd5, 4'd6: begin
                    if (a == 0) begin
                        r = 8'd0; q = 2'b01; e = 1'b1;
                    end else begin
                        v = (op == 4'd5) ? (b / a) : (b % a);
                        r = v[7:0]; q = 2'b10;
                    end
                end
                default: begin r = 8'd0; q = 2'b01; e = 1'b1; end
            endcase
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] pv);
        opcode   = op;
        operands = {a, b};
        push_val = pv;
        in_valid = 1'b1;
        #1;
        check_val("issue_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [7:0] r, input logic [1:0] q,
                             input logic e);
        check_val({tag, "_valid"}, out_valid, 1);
        check_val({tag, "_res"}, result, r);
        check_val({tag, "_qop"}, queue_op, q);
        check_val({tag, "_err"}, has_calc_err, e);
    endtask

    task automatic pop_compare();
        if (exp_res_q.size() == 0) begin
            check_val("spurious_out", 1, 0);
        end else begin
            check_val("rnd_res", result, exp_res_q.pop_front());
            check_val("rnd_qop", queue_op, exp_qop_q.pop_front());
            check_val("rnd_err", has_calc_err, exp_err_q.pop_front());
        end
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int ov_seen;
        int accepts;
        int cycles;
        int r;
        logic [7:0] er;
        logic [1:0] eq;
        logic       ee;

        rst = 1'b1; in_valid = 1'b0; opcode = 4'd0; operands = 16'd0;
        push_val = 8'd0; out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_result", result, 0);
        check_val("rst_qop", queue_op, 1);
        check_val("rst_err", has_calc_err, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_in_ready", in_ready, 1);

        // ADD with wrap or clamp, latency one
        issue(4'b0010, 8'd200, 8'd100, 8'd0);
`ifdef QALU_SAT_EN
        check_out("add", 8'd255, 2'b10, 1'b0);
`else
        check_out("add", 8'd44, 2'b10, 1'b0);
`endif

        // DIV: 8 busy cycles, result at cycle 9
        issue(4'b0101, 8'd7, 8'd100, 8'd0);
        lat = 1; busy_cnt = 0;
        while (!out_valid && lat < 20) begin
            if (busy) busy_cnt++;
            check_val("div_in_ready", in_ready, 0);
            tick();
            lat++;
        end
        check_val("div_latency", lat, 9);
        check_val("div_busy_cycles", busy_cnt, 8);
        check_val("div_busy_end", busy, 0);
        check_out("div", 8'd14, 2'b10, 1'b0);

        // REM
        issue(4'b0110, 8'd7, 8'd100, 8'd0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_val("rem_latency", lat, 9);
        check_out("rem", 8'd2, 2'b10, 1'b0);

        // Divide by zero: immediate error, no divider activity
        issue(4'b0101, 8'd0, 8'd50, 8'd0);
        check_val("div0_busy", busy, 0);
        check_out("div0", 8'd0, 2'b01, 1'b1);
        issue(4'b0000, 8'd0, 8'd0, 8'd9);
        check_out("push9", 8'd9, 2'b00, 1'b0);

        // Back-pressure: output held, second request waits
        issue(4'b0000, 8'd0, 8'd0, 8'd5);
        out_ready = 1'b0;
        in_valid  = 1'b1; opcode = 4'b0000; push_val = 8'd77;
        repeat (4) begin
            #1;
            check_out("bp_hold", 8'd5, 2'b00, 1'b0);
            check_val("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check_val("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check_out("bp_next", 8'd77, 2'b00, 1'b0);

        // Reset in the 4th divide cycle
        issue(4'b0101, 8'd7, 8'd100, 8'd0);
        repeat (3) tick();
        check_val("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_val("mid_rst_valid", out_valid, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_result", result, 0);
        check_val("mid_rst_qop", queue_op, 1);
        check_val("mid_rst_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        ov_seen = 0;
        repeat (12) begin
            if (out_valid) ov_seen++;
            tick();
        end
        check_val("no_stale_valid", ov_seen, 0);
        issue(4'b0100, 8'd3, 8'd1, 8'd0);
`ifdef QALU_SAT_EN
        check_out("sub", 8'd0, 2'b10, 1'b0);
`else
        check_out("sub", 8'd254, 2'b10, 1'b0);
`endif

        // Marker, undefined and POP opcodes
        issue(4'b1010, 8'd4, 8'd4, 8'd4);
        check_out("marker", 8'd0, 2'b01, 1'b0);
        issue(4'b0111, 8'd4, 8'd4, 8'd4);
        check_out("undef", 8'd0, 2'b01, 1'b1);
        issue(4'b0001, 8'd4, 8'd4, 8'd4);
        check_out("pop", 8'd0, 2'b11, 1'b0);

        // Randomized traffic with random back-pressure
        out_ready = 1'b1;
        tick();
        accepts = 0; cycles = 0;
        while (accepts < 300 && cycles < 20000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 19);
            opcode = (r < 14) ? 4'(r % 7) : 4'($urandom_range(7, 15));
            operands[15:8] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            operands[7:0]  = 8'($urandom);
            push_val  = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) pop_compare();
            if (in_valid && in_ready) begin
                ref_model(opcode, int'(operands[15:8]), int'(operands[7:0]), int'(push_val),
                          er, eq, ee);
                exp_res_q.push_back(er);
                exp_qop_q.push_back(eq);
                exp_err_q.push_back(ee);
                accepts++;
            end
            tick();
            cycles++;
        end
        check_val("rnd_accepts", accepts, 300);

        in_valid = 1'b0; out_ready = 1'b1;
        cycles = 0;
        while (exp_res_q.size() != 0 && cycles < 50) begin
            #1;
            if (out_valid) pop_compare();
            tick();
            cycles++;
        end
        check_val("drain_empty", exp_res_q.size(), 0);
        #1;
        check_val("final_idle_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
